// File: rtl/mm_stream_ctrl_if.sv
// Stream, RAM-port and engine-handshake bundle of the matrix-multiply frame sequencer.
// master = the sequencer, slave = stream endpoints, RAMs and engine around it.
interface mm_stream_ctrl_if #(
   parameter int width          = 8,
   parameter int A_depth_bits   = 9,
   parameter int B_depth_bits   = 9,
   parameter int RES_depth_bits = 9
);
   logic [width-1:0]          s_data;
   logic                      s_valid;
   logic                      s_ready;
   logic                      s_last;
   logic [width-1:0]          m_data;
   logic                      m_valid;
   logic                      m_ready;
   logic                      m_last;
   logic                      A_write_en;
   logic [A_depth_bits-1:0]   A_write_address;
   logic [width-1:0]          A_write_data_in;
   logic                      B_write_en;
   logic [B_depth_bits-1:0]   B_write_address;
   logic [width-1:0]          B_write_data_in;
   logic                      RES_read_en;
   logic [RES_depth_bits-1:0] RES_read_address;
   logic [width-1:0]          RES_read_data_out;
   logic                      mm_start;
   logic                      mm_done;
   logic                      busy;
   logic                      frame_err;

   modport master (
      input  s_data, s_valid, s_last, m_ready, RES_read_data_out, mm_done,
      output s_ready, m_data, m_valid, m_last,
             A_write_en, A_write_address, A_write_data_in,
             B_write_en, B_write_address, B_write_data_in,
             RES_read_en, RES_read_address, mm_start, busy, frame_err
   );

   modport slave (
      output s_data, s_valid, s_last, m_ready, RES_read_data_out, mm_done,
      input  s_ready, m_data, m_valid, m_last,
             A_write_en, A_write_address, A_write_data_in,
             B_write_en, B_write_address, B_write_data_in,
             RES_read_en, RES_read_address, mm_start, busy, frame_err
   );
endinterface

// File: rtl/mm_stream_ctrl.sv
// Frame sequencer: loads A then B from one input stream, runs the matrix-multiply
// engine with a Start/Done handshake, then streams the result RAM out row-major.
module mm_stream_ctrl #(
   parameter int width          = 8,
   parameter int A_depth_bits   = 9,
   parameter int B_depth_bits   = 9,
   parameter int RES_depth_bits = 9,
   parameter int M              = 64,
   parameter int N              = 8,
   parameter int P              = 4
) (
   input  logic             clk,
   input  logic             reset,
   mm_stream_ctrl_if.master bus
);
   localparam int A_BEATS   = M * N;
   localparam int B_BEATS   = N * P;
   localparam int RES_WORDS = M * P;
   localparam int CNT_MAX   = (A_BEATS > B_BEATS) ? A_BEATS - 1 : B_BEATS - 1;
   localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int R_W       = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS - 1);
   localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_BEATS - 1);
   localparam logic [R_W-1:0]   R_LAST = R_W'(RES_WORDS - 1);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, FETCH, OUTPUT} state_t;

   state_t                    r_state;
   logic [CNT_W-1:0]          r_cnt;
   logic [R_W-1:0]            r_idx;
   logic                      r_s_ready;
   logic [width-1:0]          r_m_data;
   logic                      r_m_valid;
   logic                      r_m_last;
   logic                      r_a_we;
   logic [A_depth_bits-1:0]   r_a_addr;
   logic [width-1:0]          r_a_data;
   logic                      r_b_we;
   logic [B_depth_bits-1:0]   r_b_addr;
   logic [width-1:0]          r_b_data;
   logic                      r_res_re;
   logic [RES_depth_bits-1:0] r_res_addr;
   logic                      r_mm_start;
   logic                      r_busy;
   logic                      r_frame_err;

   logic w_s_fire;
   assign w_s_fire = r_s_ready & bus.s_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_s_ready   <= 1'b0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_a_we      <= 1'b0;
         r_a_addr    <= '0;
         r_a_data    <= '0;
         r_b_we      <= 1'b0;
         r_b_addr    <= '0;
         r_b_data    <= '0;
         r_res_re    <= 1'b0;
         r_res_addr  <= '0;
         r_mm_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_a_we   <= 1'b0;
         r_b_we   <= 1'b0;
         r_res_re <= 1'b0;
         case (r_state)
            IDLE: begin
               r_s_ready <= 1'b1;
               if (w_s_fire) begin
                  r_a_we      <= 1'b1;
                  r_a_addr    <= '0;
                  r_a_data    <= bus.s_data;
                  r_frame_err <= bus.s_last;
                  r_busy      <= 1'b1;
                  r_cnt       <= CNT_W'(1);
                  r_state     <= LOAD_A;
               end
            end
            LOAD_A: begin
               if (w_s_fire) begin
                  r_a_we   <= 1'b1;
                  r_a_addr <= A_depth_bits'(r_cnt);
                  r_a_data <= bus.s_data;
                  if (bus.s_last) r_frame_err <= 1'b1;
                  if (r_cnt == A_LAST) begin
                     r_cnt   <= '0;
                     r_state <= LOAD_B;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            LOAD_B: begin
               if (w_s_fire) begin
                  r_b_we   <= 1'b1;
                  r_b_addr <= B_depth_bits'(r_cnt);
                  r_b_data <= bus.s_data;
                  if (r_cnt == B_LAST) begin
                     if (!bus.s_last) r_frame_err <= 1'b1;
                     r_s_ready <= 1'b0;
                     r_state   <= COMPUTE;
                  end else begin
                     if (bus.s_last) r_frame_err <= 1'b1;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            COMPUTE: begin
               // Start waits one cycle after entry so the final B write has landed.
               if (!r_mm_start) begin
                  r_mm_start <= 1'b1;
               end else if (bus.mm_done) begin
                  r_mm_start <= 1'b0;
                  r_idx      <= '0;
                  r_res_re   <= 1'b1;
                  r_res_addr <= '0;
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               r_state <= OUTPUT;
            end
            OUTPUT: begin
               // First OUTPUT cycle captures the RAM word; afterwards the word is held for the handshake.
               if (!r_m_valid) begin
                  r_m_data  <= bus.RES_read_data_out;
                  r_m_valid <= 1'b1;
                  r_m_last  <= (r_idx == R_LAST);
               end else if (bus.m_ready) begin
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
                  if (r_idx == R_LAST) begin
                     r_busy    <= 1'b0;
                     r_s_ready <= 1'b1;
                     r_state   <= IDLE;
                  end else begin
                     r_idx      <= r_idx + R_W'(1);
                     r_res_re   <= 1'b1;
                     r_res_addr <= RES_depth_bits'(r_idx + R_W'(1));
                     r_state    <= FETCH;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_ready          = r_s_ready;
   assign bus.m_data           = r_m_data;
   assign bus.m_valid          = r_m_valid;
   assign bus.m_last           = r_m_last;
   assign bus.A_write_en       = r_a_we;
   assign bus.A_write_address  = r_a_addr;
   assign bus.A_write_data_in  = r_a_data;
   assign bus.B_write_en       = r_b_we;
   assign bus.B_write_address  = r_b_addr;
   assign bus.B_write_data_in  = r_b_data;
   assign bus.RES_read_en      = r_res_re;
   assign bus.RES_read_address = r_res_addr;
   assign bus.mm_start         = r_mm_start;
   assign bus.busy             = r_busy;
   assign bus.frame_err        = r_frame_err;
endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Bench for mm_stream_ctrl: RAM and engine models around the sequencer, randomized frames
// checked against a matrix-product reference computed from the sent frame.
module tb_mm_stream_ctrl;
   localparam int W  = 8;
   localparam int M  = 64;
   localparam int N  = 8;
   localparam int P  = 4;
   localparam int NA = M * N;
   localparam int NB = N * P;
   localparam int NR = M * P;
   localparam int NT = NA + NB;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mm_stream_ctrl_if #(.width(W), .A_depth_bits(9), .B_depth_bits(9), .RES_depth_bits(9)) bus();

   mm_stream_ctrl #(.width(W), .A_depth_bits(9), .B_depth_bits(9), .RES_depth_bits(9),
                    .M(M), .N(N), .P(P)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Environment: A/B/RES RAMs and an engine whose result is (sum A*B) >> 4, truncated.
   logic [7:0] a_mem [512];
   logic [7:0] b_mem [512];
   logic [7:0] res_mem [512];
   logic [7:0] res_q;
   logic       eng_done;
   logic       stray_done = 1'b0;
   int         eng_cnt;
   int         cyc = 0;
   int         a_wr_cnt = 0, b_wr_cnt = 0, a_addr_bad = 0, b_addr_bad = 0;
   int         last_b_cyc = 0, start_cyc = 0, b_cnt_at_start = 0;
   logic       start_d = 1'b0;

   assign bus.mm_done           = eng_done | stray_done;
   assign bus.RES_read_data_out = res_q;

   function automatic logic [7:0] eng_dot(input int i, input int k);
      int s = 0;
      for (int j = 0; j < N; j++) s += int'(a_mem[i*N+j]) * int'(b_mem[j*P+k]);
      return 8'(s >> 4);
   endfunction

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      start_d <= bus.mm_start;
      if (!bus.busy) begin
         a_wr_cnt <= 0; b_wr_cnt <= 0; a_addr_bad <= 0; b_addr_bad <= 0;
      end else begin
         if (bus.A_write_en) begin
            a_mem[bus.A_write_address] <= bus.A_write_data_in;
            if (int'(bus.A_write_address) != a_wr_cnt) a_addr_bad <= a_addr_bad + 1;
            a_wr_cnt <= a_wr_cnt + 1;
         end
         if (bus.B_write_en) begin
            b_mem[bus.B_write_address] <= bus.B_write_data_in;
            if (int'(bus.B_write_address) != b_wr_cnt) b_addr_bad <= b_addr_bad + 1;
            b_wr_cnt   <= b_wr_cnt + 1;
            last_b_cyc <= cyc;
         end
      end
      if (bus.mm_start && !start_d) begin
         start_cyc      <= cyc;
         b_cnt_at_start <= b_wr_cnt;
      end
      if (bus.RES_read_en) res_q <= res_mem[bus.RES_read_address];
   end

   always @(posedge clk) begin
      if (reset || !bus.mm_start) begin
         eng_done <= 1'b0;
         eng_cnt  <= 0;
      end else if (!eng_done) begin
         if (eng_cnt == 8) begin
            for (int i = 0; i < M; i++)
               for (int k = 0; k < P; k++) res_mem[i*P+k] <= eng_dot(i, k);
            eng_done <= 1'b1;
         end
         eng_cnt <= eng_cnt + 1;
      end
   end

   // Reference model and capture buffers
   logic [7:0] frm [NT];
   logic [7:0] exp_q [NR];
   logic [7:0] rx_data [NR];
   logic       rx_last [NR];
   int         rx_n, rx_unstable;
   int         snap_a, snap_b, snap_abad, snap_bbad;
   logic       ferr_l1, ferr_first, stray_s_ready, stray_start, stray_busy;
   int         tmp;

   task automatic make_frame(input int kind);
      for (int b = 0; b < NA; b++)
         frm[b] = (kind == 0) ? (((b / N) == (b % N)) ? 8'd16 : 8'd0) : 8'($urandom);
      for (int b = 0; b < NB; b++)
         frm[NA+b] = (kind == 0) ? 8'(16 * (b / P) + (b % P)) : 8'($urandom);
   endtask

   task automatic build_expected();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < P; k++) begin
            int s = 0;
            for (int j = 0; j < N; j++) s += int'(frm[i*N+j]) * int'(frm[NA+j*P+k]);
            exp_q[i*P+k] = 8'(s >> 4);
         end
   endtask

   function automatic int count_mismatch();
      int n = 0;
      for (int w = 0; w < rx_n; w++) if (rx_data[w] !== exp_q[w]) n++;
      return n;
   endfunction

   function automatic int count_last_bad();
      int n = 0;
      for (int w = 0; w < rx_n; w++) if (rx_last[w] !== (w == NR - 1)) n++;
      return n;
   endfunction

   task automatic send_frame(input int gap_mode, input int l1, input int l2, input int stray_at);
      int beat = 0, guard = 0, par = 0;
      bit drive, samp_l1 = 0, samp_first = 0, samp_stray = 0;
      while (beat < NT && guard < 6000) begin
         @(negedge clk);
         guard++;
         stray_done = 1'b0;
         if (samp_l1) begin ferr_l1 = bus.frame_err; samp_l1 = 0; end
         if (samp_first) begin ferr_first = bus.frame_err; samp_first = 0; end
         if (samp_stray) begin
            stray_s_ready = bus.s_ready; stray_start = bus.mm_start; stray_busy = bus.busy;
            samp_stray = 0;
         end
         case (gap_mode)
            0:       drive = 1'b1;
            1:       drive = (par % 2) == 0;
            default: drive = $urandom_range(0, 3) != 0;
         endcase
         par++;
         bus.s_valid = drive;
         bus.s_data  = frm[beat];
         bus.s_last  = (beat == l1) || (beat == l2);
         if (drive && bus.s_ready) begin
            if (beat == l1) samp_l1 = 1;
            if (beat == 0) samp_first = 1;
            if (beat == stray_at) begin stray_done = 1'b1; samp_stray = 1; end
            beat++;
         end
      end
      @(negedge clk);
      bus.s_valid = 1'b0; bus.s_last = 1'b0; stray_done = 1'b0;
      if (samp_first) ferr_first = bus.frame_err;
      if (samp_stray) begin
         stray_s_ready = bus.s_ready; stray_start = bus.mm_start; stray_busy = bus.busy;
      end
      @(negedge clk);
      snap_a = a_wr_cnt; snap_b = b_wr_cnt; snap_abad = a_addr_bad; snap_bbad = b_addr_bad;
      checks++;
      if (beat != NT) begin
         errors++;
         $display("FAIL send_timeout: beats accepted %0d, required %0d", beat, NT);
      end
   endtask

   task automatic recv_frame(input int bp_mode, input int abort_after);
      int got = 0, guard = 0, stall = 0;
      bit prev_stalled = 0;
      logic [7:0] pd = '0;
      logic pl = 1'b0;
      rx_unstable = 0;
      while (got < NR && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (bus.m_valid) begin
            if (prev_stalled && (bus.m_data !== pd || bus.m_last !== pl)) rx_unstable++;
            if (!prev_stalled)
               stall = (bp_mode == 1) ? ((got % 3 == 2) ? 5 : 0)
                     : (bp_mode == 2) ? $urandom_range(0, 2) : 0;
            if (stall > 0) begin
               bus.m_ready = 1'b0; stall--; prev_stalled = 1;
               pd = bus.m_data; pl = bus.m_last;
            end else begin
               bus.m_ready = 1'b1; prev_stalled = 0;
               rx_data[got] = bus.m_data; rx_last[got] = bus.m_last;
               got++;
               if (got == abort_after) break;
            end
         end else begin
            bus.m_ready = (bp_mode == 0);
            prev_stalled = 0;
         end
      end
      rx_n = got;
   endtask

   task automatic run_frame(input int gap_mode, input int l1, input int l2, input int stray_at,
                            input int bp_mode, input int abort_after);
      build_expected();
      fork
         send_frame(gap_mode, l1, l2, stray_at);
         recv_frame(bp_mode, abort_after);
      join
      @(negedge clk);
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_last, bus.A_write_en, bus.B_write_en, bus.RES_read_en,
           bus.mm_start, bus.busy, bus.frame_err} !== 9'd0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 000000000", {bus.s_ready, bus.m_valid,
                  bus.m_last, bus.A_write_en, bus.B_write_en, bus.RES_read_en, bus.mm_start,
                  bus.busy, bus.frame_err});
      end
      checks++;
      if ({bus.m_data, bus.A_write_address, bus.B_write_address, bus.RES_read_address} !== 35'd0) begin
         errors++;
         $display("FAIL reset_values: m_data/addresses nonzero (m_data=%0h)", bus.m_data);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL idle_ready: s_ready,busy=%b, required 10", {bus.s_ready, bus.busy});
      end
      $display("test_reset done");
   endtask

   task automatic test_identity();
      make_frame(0);
      run_frame(0, -1, NT - 1, -1, 0, -1);
      checks++;
      if (rx_n !== NR) begin errors++; $display("FAIL ident_count: got %0d words, required %0d", rx_n, NR); end
      tmp = 0;
      for (int w = 0; w < rx_n; w++)
         if (rx_data[w] !== (((w / P) < N) ? 8'(16 * (w / P) + (w % P)) : 8'd0)) tmp++;
      checks++;
      if (tmp != 0) begin errors++; $display("FAIL ident_data: %0d words wrong, required 0", tmp); end
      checks++;
      if (count_last_bad() != 0) begin errors++; $display("FAIL ident_last: %0d bad m_last, required 0", count_last_bad()); end
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ident_ferr: got %b, required 0", bus.frame_err); end
      checks++;
      if (start_cyc <= last_b_cyc || b_cnt_at_start != NB) begin
         errors++;
         $display("FAIL ident_start: start at %0d, last B write %0d, B writes %0d, required later and %0d",
                  start_cyc, last_b_cyc, b_cnt_at_start, NB);
      end
      $display("test_identity: words=%0d", rx_n);
   endtask

   task automatic test_gaps();
      make_frame(1);
      run_frame(1, -1, NT - 1, -1, 0, -1);
      checks++;
      if (snap_a != NA || snap_b != NB) begin
         errors++;
         $display("FAIL gaps_writes: A=%0d B=%0d, required %0d and %0d", snap_a, snap_b, NA, NB);
      end
      checks++;
      if (snap_abad != 0 || snap_bbad != 0) begin
         errors++;
         $display("FAIL gaps_addr: out-of-order A=%0d B=%0d, required 0", snap_abad, snap_bbad);
      end
      checks++;
      if (rx_n !== NR || count_mismatch() != 0) begin
         errors++;
         $display("FAIL gaps_data: words=%0d wrong=%0d, required %0d and 0", rx_n, count_mismatch(), NR);
      end
      $display("test_gaps: words=%0d", rx_n);
   endtask

   task automatic test_backpressure();
      make_frame(1);
      run_frame(0, -1, NT - 1, -1, 1, -1);
      checks++;
      if (rx_unstable != 0) begin errors++; $display("FAIL bp_stable: %0d changes while stalled, required 0", rx_unstable); end
      checks++;
      if (rx_n !== NR || count_mismatch() != 0) begin
         errors++;
         $display("FAIL bp_data: words=%0d wrong=%0d, required %0d and 0", rx_n, count_mismatch(), NR);
      end
      checks++;
      if (count_last_bad() != 0) begin errors++; $display("FAIL bp_last: %0d bad m_last, required 0", count_last_bad()); end
      $display("test_backpressure: words=%0d", rx_n);
   endtask

   task automatic test_frame_err();
      make_frame(1);
      run_frame(2, 100, NT - 1, -1, 0, -1);
      checks++;
      if (ferr_l1 !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b after beat 100, required 1", ferr_l1); end
      checks++;
      if (rx_n !== NR || count_mismatch() != 0) begin
         errors++;
         $display("FAIL ferr_data: words=%0d wrong=%0d, required %0d and 0", rx_n, count_mismatch(), NR);
      end
      checks++;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b, required 1", bus.frame_err); end
      make_frame(1);
      run_frame(0, -1, NT - 1, -1, 2, -1);
      checks++;
      if (ferr_first !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b after first beat, required 0", ferr_first); end
      checks++;
      if (rx_n !== NR || count_mismatch() != 0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL ferr_clean: words=%0d wrong=%0d ferr=%b, required %0d, 0, 0",
                  rx_n, count_mismatch(), bus.frame_err, NR);
      end
      $display("test_frame_err: words=%0d", rx_n);
   endtask

   task automatic test_reset_output();
      make_frame(1);
      run_frame(0, -1, NT - 1, -1, 0, 41);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_last, bus.A_write_en, bus.B_write_en, bus.RES_read_en,
           bus.mm_start, bus.busy, bus.frame_err} !== 9'd0 || bus.m_data !== 8'd0) begin
         errors++;
         $display("FAIL rst_out: flags=%b m_data=%0h, required all zero", {bus.s_ready, bus.m_valid,
                  bus.m_last, bus.A_write_en, bus.B_write_en, bus.RES_read_en, bus.mm_start,
                  bus.busy, bus.frame_err}, bus.m_data);
      end
      reset = 1'b0;
      make_frame(1);
      run_frame(2, -1, NT - 1, -1, 2, -1);
      checks++;
      if (rx_n !== NR || count_mismatch() != 0 || count_last_bad() != 0) begin
         errors++;
         $display("FAIL rst_next: words=%0d wrong=%0d badlast=%0d, required %0d, 0, 0",
                  rx_n, count_mismatch(), count_last_bad(), NR);
      end
      $display("test_reset_output: words=%0d", rx_n);
   endtask

   task automatic test_stray_done();
      make_frame(1);
      run_frame(0, -1, NT - 1, 200, 0, -1);
      checks++;
      if ({stray_s_ready, stray_start, stray_busy} !== 3'b101) begin
         errors++;
         $display("FAIL stray_state: s_ready,mm_start,busy=%b, required 101",
                  {stray_s_ready, stray_start, stray_busy});
      end
      checks++;
      if (start_cyc <= last_b_cyc || b_cnt_at_start != NB) begin
         errors++;
         $display("FAIL stray_start: start at %0d, last B write %0d, B writes %0d, required later and %0d",
                  start_cyc, last_b_cyc, b_cnt_at_start, NB);
      end
      checks++;
      if (rx_n !== NR || count_mismatch() != 0) begin
         errors++;
         $display("FAIL stray_data: words=%0d wrong=%0d, required %0d and 0", rx_n, count_mismatch(), NR);
      end
      $display("test_stray_done: words=%0d", rx_n);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      test_reset();
      test_identity();
      test_gaps();
      test_backpressure();
      test_frame_err();
      test_reset_output();
      test_stray_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
